// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED blink scheduler.
// Contents: FSM state encoding, blink-count width and heartbeat period multiple.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int COUNT_W        = 4;
  // Heartbeat half-period, in units of TICK_DIV cycles.
  localparam int HEARTBEAT_MULT = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Half-period prescaler: counts 0..DIV-1 and wraps.
// Ports:
//   clk   - clock (posedge)
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear of the count
//   tick  - high while the count equals DIV-1 (the wrap cycle)
module led_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_blink_sched.sv
// Shares one status LED between NREQ requesters. Each requester posts a
// blink count (0..15) over valid/ready; grants are round-robin and each
// code plays as count x (ON, OFF) half-periods followed by an LED-off gap.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester offer
//   req_count   - 4-bit count per requester, [4i+3:4i]
//   req_ready   - one-hot grant, only in IDLE
//   led_on      - LED drive, active-high
//   owner       - one-hot owner of the running code, 0 when idle
//   busy        - state is not IDLE
//   done        - one-cycle pulse on the first IDLE cycle after a gap
// Optional: define LED_SCHED_HEARTBEAT_EN for a slow heartbeat on the LED
// while idle (toggles every HEARTBEAT_MULT*TICK_DIV cycles).
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_TICKS = 4,
  parameter int NREQ      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [COUNT_W*NREQ-1:0] req_count,
  output logic [NREQ-1:0]         req_ready,
  output logic                    led_on,
  output logic [NREQ-1:0]         owner,
  output logic                    busy,
  output logic                    done
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  // First valid requester at or after ptr, wrapping. Scanning backwards
  // lets the last hit be the winner.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0]  vld,
                                              input logic [PTR_W-1:0] ptr);
    logic [NREQ-1:0] g;
    int              idx;
    g = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (vld[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) r = PTR_W'(i);
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NREQ-1:0]    owner_q, owner_d;
  logic               done_q, done_d;
  logic               led_q, led_d;

  logic [NREQ-1:0]    grant;
  logic [PTR_W-1:0]   gidx;
  logic [COUNT_W-1:0] count_sel;
  logic               accept;
  logic               tick;

  assign grant     = (state_q == IDLE) ? rr_pick(req_valid, ptr_q) : '0;
  assign accept    = |grant;
  assign gidx      = onehot_idx(grant);
  assign count_sel = req_count[COUNT_W*int'(gidx) +: COUNT_W];

  assign req_ready = grant;
  assign led_on    = led_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Prescaler restarts on acceptance so the first ON phase is a full one.
  led_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          rem_d   = count_sel;
          ptr_d   = PTR_W'((int'(gidx) + 1) % NREQ);
          gap_d   = '0;
          state_d = (count_sel != '0) ? ON : GAP;
        end
      end
      ON: begin
        if (tick) state_d = OFF;
      end
      OFF: begin
        if (tick) begin
          // rem_q is at least 1 here, so this never wraps.
          rem_d   = rem_q - COUNT_W'(1);
          state_d = (rem_q == COUNT_W'(1)) ? GAP : ON;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            owner_d = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_SCHED_HEARTBEAT_EN
  localparam int HB_PERIOD = HEARTBEAT_MULT * TICK_DIV;
  localparam int HB_W      = $clog2(HB_PERIOD);

  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;

  // Runs only while idle with nothing being accepted; anything else
  // restarts it from LED-off so each IDLE entry begins a fresh period.
  always_comb begin
    hb_cnt_d = '0;
    hb_d     = 1'b0;
    if (state_q == IDLE && !accept) begin
      if (hb_cnt_q == HB_W'(HB_PERIOD - 1)) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
        hb_d     = hb_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign led_d = (state_d == ON) || ((state_d == IDLE) && hb_d);
`else
  assign led_d = (state_d == ON);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      owner_q <= '0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

endmodule
